// File: rtl/ysyx_23060201_gpr_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_gpr_pkg
// Shared constants and helpers for the scoreboarded GPR file.
//   GPR_AW_DEF  : default register index width (depth = 2**AW)
//   GPR_DW_DEF  : default register data width
//   NR_RD_DEF   : default number of read ports
//   NR_RD_MAX   : largest supported number of read ports
//   port_lsb()  : LSB position of read port i's address slice in rd_addr
// ---------------------------------------------------------------------------
package ysyx_23060201_gpr_pkg;

  localparam int GPR_AW_DEF = 5;
  localparam int GPR_DW_DEF = 32;
  localparam int NR_RD_DEF  = 2;
  localparam int NR_RD_MAX  = 4;

  // Port i's address lives at rd_addr[port_lsb(i, aw) +: aw].
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned aw);
    return port * aw;
  endfunction

endpackage

// File: rtl/ysyx_23060201_gpr_sb_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_gpr_sb_if
// Bundle of decode/writeback signals for the scoreboarded GPR file.
//   rd_en/rd_addr -> rd_data/rd_busy : NR_RD combinational read ports
//   wr_en/wr_addr/wr_data            : writeback
//   iss_en/iss_addr                  : issue of an instruction with a dest
//   flush                            : clear all busy flags
//   busy_any                         : registered OR of all busy flags
// Handshake: there is no valid/ready pair. wr_en and iss_en are single-cycle
// qualifiers that are always accepted on the posedge they are high; read
// ports answer combinationally in the same cycle with no back-pressure.
// master = pipeline side (decode/writeback), slave = register file.
// ---------------------------------------------------------------------------
interface ysyx_23060201_gpr_sb_if
  import ysyx_23060201_gpr_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = GPR_AW_DEF,
  parameter int DATA_WIDTH     = GPR_DW_DEF,
  parameter int NR_RD          = NR_RD_DEF
);

  logic [NR_RD-1:0]                rd_en;
  logic [NR_RD*GPR_ADDR_WIDTH-1:0] rd_addr;
  logic [NR_RD*DATA_WIDTH-1:0]     rd_data;
  logic [NR_RD-1:0]                rd_busy;
  logic                            wr_en;
  logic [GPR_ADDR_WIDTH-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            iss_en;
  logic [GPR_ADDR_WIDTH-1:0]       iss_addr;
  logic                            flush;
  logic                            busy_any;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_any
  );

endinterface

// File: rtl/ysyx_23060201_gpr_rdport.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_gpr_rdport
// One combinational read port of the scoreboarded GPR file.
//   rd_en, rd_addr     : port enable and register index
//   wr_en/addr/data    : same-cycle writeback, used only for bypass
//   mem, busy          : current register contents and busy flags
//   rd_data, rd_busy   : 0 / not-busy when disabled or addressing x0
// Optional feature macro: YSYX_23060201_GPR_BYPASS_EN (forward a same-cycle
// writeback to the reader and report the register as not busy).
// ---------------------------------------------------------------------------
module ysyx_23060201_gpr_rdport
  import ysyx_23060201_gpr_pkg::*;
#(
  parameter int AW    = GPR_AW_DEF,
  parameter int DW    = GPR_DW_DEF,
  parameter int DEPTH = 2 ** AW
) (
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [DW-1:0]    mem [DEPTH],
  input  logic [DEPTH-1:0] busy,
  output logic [DW-1:0]    rd_data,
  output logic             rd_busy
);

`ifdef YSYX_23060201_GPR_BYPASS_EN
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_en && (rd_addr != '0)) begin
      // The writeback completes the older producer; a same-cycle issue to the
      // same register belongs to a younger instruction and is not visible here.
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end else begin
        rd_data = mem[rd_addr];
        rd_busy = busy[rd_addr];
      end
    end
  end
`else
  // Writeback inputs only matter for forwarding.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_en && (rd_addr != '0)) begin
      rd_data = mem[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/ysyx_23060201_gpr_sb.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_gpr_sb
// General-purpose register file with per-register busy scoreboard and NR_RD
// combinational read ports. x0 reads as zero and is never busy.
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset (clears data, busy, busy_any)
//   bus  : slave side of ysyx_23060201_gpr_sb_if (read ports, writeback,
//          issue, flush, busy_any)
// Busy update priority per cycle: rst > flush > issue > writeback.
// Optional feature macro: YSYX_23060201_GPR_BYPASS_EN (write-to-read bypass
// inside each read port).
// ---------------------------------------------------------------------------
module ysyx_23060201_gpr_sb
  import ysyx_23060201_gpr_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = GPR_AW_DEF,
  parameter int DATA_WIDTH     = GPR_DW_DEF,
  parameter int NR_RD          = NR_RD_DEF
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_23060201_gpr_sb_if.slave bus
);

  localparam int AW    = GPR_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             busy_any_q, busy_any_d;

  logic wr_fire, iss_fire;
  assign wr_fire  = bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_fire = bus.iss_en && (bus.iss_addr != '0);

  // Data writes are independent of flush: a squash only drops tracking.
  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Writeback clear is applied before the issue set so that an issue to the
  // same register in the same cycle leaves it busy (new producer wins).
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (wr_fire) begin
        busy_d[bus.wr_addr] = 1'b0;
      end
      if (iss_fire) begin
        busy_d[bus.iss_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Derived from the next-state vector so busy_any lines up with busy_q.
  assign busy_any_d = |busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign bus.busy_any = busy_any_q;

  for (genvar i = 0; i < NR_RD; i++) begin : g_rd
    ysyx_23060201_gpr_rdport #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_rdport (
      .rd_en   (bus.rd_en[i]),
      .rd_addr (bus.rd_addr[port_lsb(i, AW) +: AW]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .mem     (mem_q),
      .busy    (busy_q),
      .rd_data (bus.rd_data[i*DW +: DW]),
      .rd_busy (bus.rd_busy[i])
    );
  end

endmodule

// File: tb/tb_ysyx_23060201_gpr_sb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060201_gpr_sb
// Directed scoreboard bench for the GPR file with three read ports. The
// stimulus thread drives one cycle of inputs and queues the read-port values
// it expects for that cycle; the monitor samples the DUT on the falling edge
// and compares against the queue head.
// ---------------------------------------------------------------------------
module tb_ysyx_23060201_gpr_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int EW = NR*DW + NR + 1;

`ifdef YSYX_23060201_GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060201_gpr_sb_if #(
    .GPR_ADDR_WIDTH (AW),
    .DATA_WIDTH     (DW),
    .NR_RD          (NR)
  ) bus ();

  ysyx_23060201_gpr_sb #(
    .GPR_ADDR_WIDTH (AW),
    .DATA_WIDTH     (DW),
    .NR_RD          (NR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk_valid = 1'b0;
  int            total = 0;
  int            bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    idle();
  endtask

  task automatic rd3(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [AW-1:0] a2);
    bus.rd_en   = '1;
    bus.rd_addr = {a2, a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
  endtask

  task automatic expect_rd(input string name, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                           input logic [NR-1:0] b, input logic any);
    exp_q.push_back({d2, d1, d0, b, any});
    name_q.push_back(name);
    chk_valid = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  string         mon_n;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor: output sampled with no expected entry queued");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        for (int p = 0; p < NR; p++) begin
          total++;
          if (bus.rd_data[p*DW +: DW] !== mon_e[NR+1+p*DW +: DW]) begin
            bad++;
            $display("FAIL %s port%0d rd_data: got %h want %h", mon_n, p,
                     bus.rd_data[p*DW +: DW], mon_e[NR+1+p*DW +: DW]);
          end
          total++;
          if (bus.rd_busy[p] !== mon_e[1+p]) begin
            bad++;
            $display("FAIL %s port%0d rd_busy: got %b want %b", mon_n, p,
                     bus.rd_busy[p], mon_e[1+p]);
          end
        end
        total++;
        if (bus.busy_any !== mon_e[0]) begin
          bad++;
          $display("FAIL %s busy_any: got %b want %b", mon_n, bus.busy_any,
                   mon_e[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd3(5, 5, 0); expect_rd("reset_state", 0, 0, 0, 3'b000, 1'b0); tick();

    // Plain write to a non-busy register, then enable masking
    wr(5, 32'h0000_1234); tick();
    rd3(5, 5, 5);
    expect_rd("x5_written", 32'h1234, 32'h1234, 32'h1234, 3'b000, 1'b0); tick();
    rd3(5, 5, 5); bus.rd_en = 3'b010;
    expect_rd("rd_en_mask", 0, 32'h1234, 0, 3'b000, 1'b0); tick();

    // Reset pulse clears data
    rst = 1'b1; tick(); rst = 1'b0;
    rd3(5, 5, 5); expect_rd("x5_after_rst", 0, 0, 0, 3'b000, 1'b0); tick();

    // x0 is never written and never busy, even with same-cycle write
    rd3(0, 0, 0); wr(0, 32'hFFFF_FFFF); iss(0);
    expect_rd("x0_same_cycle", 0, 0, 0, 3'b000, 1'b0); tick();
    rd3(0, 0, 0); expect_rd("x0_after", 0, 0, 0, 3'b000, 1'b0); tick();

    // Scoreboard on x7
    iss(7); tick();
    rd3(7, 7, 0); expect_rd("x7_busy", 0, 0, 0, 3'b011, 1'b1); tick();
    rd3(7, 7, 0); wr(7, 32'hA5A5_A5A5);
    expect_rd("x7_wb_same", BYP ? 32'hA5A5_A5A5 : 32'h0,
              BYP ? 32'hA5A5_A5A5 : 32'h0, 0, BYP ? 3'b000 : 3'b011, 1'b1);
    tick();
    rd3(7, 7, 0);
    expect_rd("x7_wb_next", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 3'b000, 1'b0); tick();

    // Bypass window on x3 (port 1 reads an unrelated register)
    iss(3); tick();
    rd3(3, 5, 3); wr(3, 32'hDEAD_BEEF);
    expect_rd("x3_wb_same", BYP ? 32'hDEAD_BEEF : 32'h0, 0,
              BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 3'b000 : 3'b101, 1'b1);
    tick();
    rd3(3, 3, 3);
    expect_rd("x3_wb_next", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
              3'b000, 1'b0);
    tick();

    // Issue and writeback to the same register in one cycle: stays busy
    iss(9); tick();
    rd3(9, 9, 9); iss(9); wr(9, 32'h55);
    expect_rd("x9_iss_wb_same", BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0,
              BYP ? 32'h55 : 32'h0, BYP ? 3'b000 : 3'b111, 1'b1);
    tick();
    rd3(9, 9, 9); expect_rd("x9_iss_wb_next", 32'h55, 32'h55, 32'h55, 3'b111, 1'b1);
    tick();
    rd3(9, 0, 9); wr(9, 32'h66);
    expect_rd("x9_wb2_same", BYP ? 32'h66 : 32'h55, 0, BYP ? 32'h66 : 32'h55,
              BYP ? 3'b000 : 3'b101, 1'b1);
    tick();
    rd3(9, 0, 9); expect_rd("x9_cleared", 32'h66, 0, 32'h66, 3'b000, 1'b0); tick();

    // Flush beats issue; the data write still lands
    iss(4); tick();
    iss(6); tick();
    rd3(4, 6, 8); expect_rd("pre_flush", 0, 0, 0, 3'b011, 1'b1); tick();
    rd3(4, 4, 4); bus.flush = 1'b1; iss(8); wr(4, 32'h11);
    expect_rd("flush_same", BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0,
              BYP ? 32'h11 : 32'h0, BYP ? 3'b000 : 3'b111, 1'b1);
    tick();
    rd3(4, 4, 4); expect_rd("flush_x4", 32'h11, 32'h11, 32'h11, 3'b000, 1'b0);
    tick();
    rd3(6, 8, 4); expect_rd("flush_others", 0, 0, 32'h11, 3'b000, 1'b0); tick();

    // Distinct registers on each port
    rd3(7, 3, 9);
    expect_rd("mixed_ports", 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h66, 3'b000, 1'b0);
    tick();

    // Mid-operation reset drops the same-cycle issue/write and pending busy
    iss(13); tick();
    iss(12); wr(12, 32'h77); rst = 1'b1; tick(); rst = 1'b0;
    rd3(12, 7, 13); expect_rd("mid_op_reset", 0, 0, 0, 3'b000, 1'b0); tick();

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
